// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// No logic; imported by fetch_controller.
// No flow control of its own.
package fetch_pkg;

  localparam int          ADDR_W_DEFAULT   = 8;
  localparam logic [7:0]  START_PC_DEFAULT = 8'h00;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0;
  localparam int          PC_STEP          = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_controller.sv
// Program-load sequencer then PC/IF-ID fetch stage for a byte-addressed instruction memory.
// Latency: load writes pass through combinationally; fetch registers the word one cycle after pc.
// Backpressure: load_ready drops once memory is full; stall holds pc and IF/ID, branch flushes.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] START_PC = ADDR_W'(START_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_done,
  output logic              load_ready,
  output logic              load_overflow,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic              running
);

  // Word alignment: clear the two byte-offset bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_nxt;
  // One extra bit so the counter can reach 2**ADDR_W and signal full without wrapping.
  logic [ADDR_W:0]   load_addr;
  logic              full;
  logic [ADDR_W-1:0] pc;

  assign full      = load_addr[ADDR_W];
  assign running   = (state == RUN);
  assign mem_raddr = pc;

  // Phase register: LOAD until load_done, then RUN until reset.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next phase and the combinational byte-write / ready outputs.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = load_addr[ADDR_W-1:0];
    mem_wdata  = load_byte;
    case (state)
      LOAD: begin
        load_ready = !full;
        mem_we     = load_valid && !full;
        if (load_done) state_nxt = RUN;
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Load address counter and sticky overflow flag; a byte beside load_done is still taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_addr     <= '0;
      load_overflow <= 1'b0;
    end else if (state == LOAD && load_valid) begin
      if (!full) load_addr     <= load_addr + 1'b1;
      else       load_overflow <= 1'b1;
    end
  end

  // PC and IF/ID register: branch beats stall beats a normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      if_pc    <= '0;
      if_instr <= BUBBLE_INSTR;
      if_valid <= 1'b0;
    end else if (state == LOAD) begin
      if (load_done) pc <= START_PC & ALIGN_MASK;
    end else begin
      if (branch_taken) begin
        pc       <= branch_target & ALIGN_MASK;
        if_instr <= BUBBLE_INSTR;
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_instr <= mem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        pc       <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed plus randomized bench for fetch_controller with a byte memory behind it.
// Reference model tracks loaded bytes and the fetch stream arithmetically.
// Inputs driven 1ns after the rising edge, outputs sampled there too.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, load_valid, load_done, stall, branch_taken;
  logic [7:0]  load_byte, branch_target;
  logic        load_ready, load_overflow, mem_we, if_valid, running;
  logic [7:0]  mem_waddr, mem_wdata, mem_raddr, if_pc;
  logic [31:0] mem_rdata, if_instr;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_byte(load_byte),
    .load_done(load_done), .load_ready(load_ready), .load_overflow(load_overflow),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .running(running)
  );

  // Instruction memory driven by the DUT's write port, big-endian combinational word read.
  logic [7:0] tbmem [256];
  logic [7:0] ra1, ra2, ra3;
  assign ra1 = mem_raddr + 8'd1;
  assign ra2 = mem_raddr + 8'd2;
  assign ra3 = mem_raddr + 8'd3;
  assign mem_rdata = {tbmem[mem_raddr], tbmem[ra1], tbmem[ra2], tbmem[ra3]};
  always @(posedge clk) if (mem_we) tbmem[mem_waddr] <= mem_wdata;

  // Reference model state.
  logic [7:0]  ref_mem [256];
  int          m_laddr = 0;
  logic        m_running = 1'b0, m_overflow = 1'b0, m_valid = 1'b0;
  logic [7:0]  m_pc = 8'h0, m_if_pc = 8'h0;
  logic [31:0] m_instr = 32'h0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {ref_mem[a], ref_mem[b1], ref_mem[b2], ref_mem[b3]};
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic lv, input logic [7:0] lb, input logic ld,
                       input logic st, input logic br, input logic [7:0] bt,
                       input logic rst);
    logic can_take;
    reset = rst; load_valid = lv; load_byte = lb; load_done = ld;
    stall = st; branch_taken = br; branch_target = bt;
    #1;
    can_take = (m_laddr < 256);
    if (!rst) begin
      if (!m_running) begin
        check("load_ready", 32'(load_ready), 32'(can_take));
        check("mem_we_load", 32'(mem_we), 32'(lv && can_take));
        if (lv && can_take) begin
          check("mem_waddr", 32'(mem_waddr), 32'(m_laddr % 256));
          check("mem_wdata", 32'(mem_wdata), 32'(lb));
        end
      end else begin
        check("mem_we_run", 32'(mem_we), 32'(0));
        check("load_ready_run", 32'(load_ready), 32'(0));
      end
      check("mem_raddr", 32'(mem_raddr), 32'(m_pc));
    end
    if (rst) begin
      m_running = 0; m_overflow = 0; m_laddr = 0;
      m_pc = 0; m_if_pc = 0; m_instr = 0; m_valid = 0;
    end else if (!m_running) begin
      if (lv) begin
        if (can_take) begin
          ref_mem[m_laddr] = lb;
          m_laddr++;
        end else m_overflow = 1;
      end
      if (ld) begin
        m_running = 1;
        m_pc = 8'h00;
      end
    end else if (br) begin
      m_pc = bt & 8'hFC; m_valid = 0; m_instr = 32'h0;
    end else if (!st) begin
      m_instr = ref_word(m_pc); m_if_pc = m_pc; m_valid = 1;
      m_pc = 8'((int'(m_pc) + 4) % 256);
    end
    @(posedge clk);
    #1;
    check("running", 32'(running), 32'(m_running));
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_instr", if_instr, m_instr);
    check("if_pc", 32'(if_pc), 32'(m_if_pc));
    check("load_overflow", 32'(load_overflow), 32'(m_overflow));
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0]  wrap_exp [4];
    logic [7:0]  held_pc;
    logic [31:0] held_instr, first_word;
    int          sent;
    logic        lv;

    wrap_exp = '{8'd248, 8'd252, 8'd0, 8'd4};

    // Reset state.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("reset_load_ready", 32'(load_ready), 32'(1));
    check("reset_running", 32'(running), 32'(0));

    // Load E3 A0 00 01, load_done alongside the last byte.
    cycle(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("enter_run", 32'(running), 32'(1));
    idle();
    check("first_instr", if_instr, 32'hE3A00001);
    check("first_pc", 32'(if_pc), 32'(0));
    check("first_valid", 32'(if_valid), 32'(1));

    // Reset, then fill memory completely with random bytes and gaps, then overflow.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    sent = 0;
    while (sent < 256) begin
      lv = ($urandom_range(3) != 0);
      cycle(lv, 8'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (lv) sent++;
    end
    check("full_ready", 32'(load_ready), 32'(0));
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("overflow_set", 32'(load_overflow), 32'(1));
    repeat (3) idle();
    check("overflow_sticky", 32'(load_overflow), 32'(1));
    first_word = ref_word(8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Sequential fetch across the top of memory.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd248, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("wrap_pc", 32'(if_pc), 32'(wrap_exp[i]));
    end

    // Stall for three cycles.
    held_pc = if_pc;
    held_instr = if_instr;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("stall_pc", 32'(if_pc), 32'(held_pc));
      check("stall_instr", if_instr, held_instr);
    end
    idle();
    check("after_stall_pc", 32'(if_pc), 32'(held_pc + 8'd4));

    // Branch while stalled, misaligned target.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0);
    check("br_raddr", 32'(mem_raddr), 32'h10);
    check("br_valid", 32'(if_valid), 32'(0));
    check("br_instr", if_instr, 32'h0);
    idle();
    check("br_if_pc", 32'(if_pc), 32'h10);

    // Random run traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)),
            ($urandom_range(3) == 0), ($urandom_range(6) == 0), 8'($urandom), 1'b0);
    end

    // Reset mid-run, re-enter RUN without loading; contents survive.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("midrst_ready", 32'(load_ready), 32'(1));
    check("midrst_raddr", 32'(mem_raddr), 32'(0));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    check("refetch_word", if_instr, first_word);
    check("refetch_pc", 32'(if_pc), 32'(0));
    repeat (5) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the byte-addressed, 256-byte instruction memory. It first runs a byte-serial program-load phase that writes the memory through its byte write port. It then runs the fetch phase: it owns the PC, drives the combinational word-read address, and registers the big-endian 32-bit word into the IF/ID stage register. It sits between the program loader/testbench, the instruction memory and the decode stage, and handles stall and branch-redirect from the pipeline.

## Interface
- START_PC, 8'h00, PC value loaded on entry to RUN
- ADDR_W, 8, byte-address width (memory depth 2**ADDR_W bytes)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  load_byte valid this cycle
- load_byte  in  8  program byte, presented in ascending address order
- load_done  in  1  end of program load; request to enter RUN
- load_ready  out  1  high in LOAD while a byte can still be accepted
- load_overflow  out  1  sticky; a byte arrived after memory was full
- mem_we  out  1  instruction memory byte write enable
- mem_waddr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- mem_raddr  out  ADDR_W  word read address (byte address of MSB)
- mem_rdata  in  32  combinational word {m[a],m[a+1],m[a+2],m[a+3]}
- stall  in  1  hold PC and IF/ID register
- branch_taken  in  1  redirect PC and flush IF/ID
- branch_target  in  ADDR_W  redirect byte address
- if_pc  out  ADDR_W  PC of instruction in IF/ID
- if_instr  out  32  fetched instruction
- if_valid  out  1  if_instr holds a real instruction
- running  out  1  high in RUN

## Operation
- States: LOAD (reset state) and RUN. There is no return from RUN except via reset.
- LOAD:
  - load_ready = !full.
  - A cycle with load_valid && !full gives mem_we=1, mem_waddr=load_addr and mem_wdata=load_byte (combinational pass-through), then load_addr++.
  - load_addr 255 -> full. full means the counter reached 2**ADDR_W; load_addr does not wrap.
  - load_valid while full gives no write and sets load_overflow.
  - load_done moves to RUN next cycle. If load_valid and load_done are asserted in the same cycle, the byte is written first.
  - pc, if_valid and running stay 0 in LOAD.
- RUN:
  - On entry, pc = START_PC & ~3.
  - mem_we = 0 throughout.
  - mem_raddr = pc, combinationally.
- Per-cycle priority in RUN: branch_taken > stall > normal.
  - **branch_taken:** pc <= branch_target & ~3 (misaligned targets are forced to word alignment), if_valid <= 0, if_instr <= 32'h0. This also applies when stall is high.
  - **stall:** pc, if_pc, if_instr and if_valid are held.
  - **normal:** if_instr <= mem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc + 4 modulo 2**ADDR_W, so 252 wraps to 0.
- Reset (any state, including mid-load or mid-run):
  - Outputs return to reset values next edge.
  - load_addr = 0 and load_overflow = 0.
  - Memory contents are not cleared.

## Timing
- Reset values are 0 for all registered outputs: if_pc, if_instr, if_valid, running, load_overflow and the pc register. load_ready is 1 after reset.
- Fetch latency is 1 cycle: the word at pc appears on if_instr the edge after pc is presented.
- Load throughput is 1 byte/cycle, and the write is visible to a read on the following cycle.
- Branch penalty is one bubble (if_valid=0 for one cycle).
- The first valid instruction appears 2 cycles after load_done: one cycle to enter RUN, one to fetch.

## Structure
- Shared package `fetch_pkg`:
  - state enum {LOAD, RUN}
  - BUBBLE_INSTR = 32'h0
  - PC_STEP = 4
  - ADDR_W default
- Single module; the PC next-state mux is kept inline.
- The instruction memory is instantiated by the parent, not inside this block.

## Test plan
- **Reset then load:** load bytes E3,A0,00,01 then load_done, with memory behind. Expect mem_we pulses at addresses 0..3, running=1 next cycle, then if_instr=32'hE3A00001 with if_pc=0 and if_valid=1.
- **Sequential fetch and wrap:** with pc=248, four unstalled cycles give if_pc sequence 248, 252, 0, 4.
- **Stall:** stall held 3 cycles. if_pc, if_instr and if_valid are frozen; pc increments resume after release with no skipped address.
- **Branch with stall:** branch_taken=1, stall=1, branch_target=8'h13. Next cycle pc=8'h10, if_valid=0 and if_instr=0; the following cycle gives if_pc=8'h10.
- **Overflow:** 257 load bytes. load_ready=0 after the 256th, the 257th is not written (mem_we=0), and load_overflow=1 until reset.
- **Reset mid-run:** reset at an arbitrary RUN cycle. State returns to LOAD with all outputs at 0 and load_ready=1. After load_done, previously loaded bytes are re-fetched unchanged from address 0.
